// File: rtl/vend_sequencer.sv
// Coin-operated sale sequencer: credit collection, single dispense, nickel change/refund, stock tracking.
// Optional inactivity refund in COLLECT is compiled in when VEND_TIMEOUT_EN is defined.
module vend_sequencer #(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned STOCK_INIT  = 8,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] coin,
  input  logic       cancel,
  input  logic       refill,
  output logic       product,
  output logic       nickel_out,
  output logic       coin_reject,
  output logic [5:0] credit,
  output logic [3:0] stock,
  output logic       sold_out,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;

  localparam logic [6:0] PRICE_W = 7'(PRICE);
  localparam logic [5:0] NICKEL  = 6'd5;
  localparam logic [3:0] STOCK_C = 4'(STOCK_INIT);

  // Out-of-range configurations elaborate an otherwise empty marker scope.
  if (TIMEOUT_CYC == 0 || TIMEOUT_CYC > 255 || PRICE % 5 != 0 || PRICE < 5 || PRICE > 50 ||
      STOCK_INIT == 0 || STOCK_INIT > 15) begin : g_param_range_violation
  end

  state_e     state_q, state_d;
  logic [5:0] credit_q, credit_d;
  logic [3:0] stock_q, stock_d;
  logic       product_q, product_d;
  logic       nickel_q, nickel_d;
  logic       reject_q, reject_d;
  logic       sold_q, sold_d;
  logic       busy_q, busy_d;

  logic       coin_any, coin_valid, stop_req;
  logic [5:0] coin_val;
  logic [6:0] sum;

`ifdef VEND_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT_CYC);
  logic [7:0] timer_q, timer_d;
`endif

  always_comb begin
    coin_any   = (coin != 2'b00);
    coin_valid = (coin == 2'b01) || (coin == 2'b10);
    coin_val   = (coin == 2'b10) ? 6'd10 : 6'd5;
    sum        = {1'b0, credit_q} + {1'b0, coin_val};
    stop_req   = cancel;
`ifdef VEND_TIMEOUT_EN
    stop_req   = cancel || (timer_q == TIMEOUT_C);
    timer_d    = '0;
`endif

    state_d   = state_q;
    credit_d  = credit_q;
    stock_d   = stock_q;
    sold_d    = sold_q;
    product_d = 1'b0;
    nickel_d  = 1'b0;
    reject_d  = 1'b0;
    // Outputs trail the state by one cycle, so busy covers exactly the product and nickel pulses.
    busy_d    = (state_q == VEND) || (state_q == CHANGE);

    unique case (state_q)
      IDLE: begin
        if (coin_valid && stock_q != '0) begin
          credit_d = coin_val;
          state_d  = COLLECT;
        end else begin
          reject_d = coin_any;
        end
        if (refill) begin
          stock_d = STOCK_C;
          sold_d  = 1'b0;
        end
      end
      COLLECT: begin
        if (stop_req) begin
          reject_d = coin_any;
          state_d  = CHANGE;
        end else if (coin_valid) begin
          if (sum >= PRICE_W) begin
            credit_d = 6'(sum - PRICE_W);
            state_d  = VEND;
          end else begin
            credit_d = sum[5:0];
          end
        end else begin
          reject_d = coin_any;
`ifdef VEND_TIMEOUT_EN
          timer_d  = timer_q + 8'd1;
`endif
        end
      end
      VEND: begin
        product_d = 1'b1;
        stock_d   = stock_q - 4'd1;
        sold_d    = (stock_q == 4'd1);
        reject_d  = coin_any;
        state_d   = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        nickel_d = 1'b1;
        reject_d = coin_any;
        if (credit_q <= NICKEL) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - NICKEL;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      credit_q  <= '0;
      stock_q   <= STOCK_C;
      sold_q    <= 1'b0;
      product_q <= 1'b0;
      nickel_q  <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      timer_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      stock_q   <= stock_d;
      sold_q    <= sold_d;
      product_q <= product_d;
      nickel_q  <= nickel_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
`ifdef VEND_TIMEOUT_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign product     = product_q;
  assign nickel_out  = nickel_q;
  assign coin_reject = reject_q;
  assign credit      = credit_q;
  assign stock       = stock_q;
  assign sold_out    = sold_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Scoreboard bench for vend_sequencer: a timeline reference model schedules expected
// pulses per edge; a monitor pops one expected snapshot per clock and compares all outputs.
module tb_vend_sequencer;

  localparam int PRICE_T   = 15;
  localparam int STOCK_T   = 8;
  localparam int TIMEOUT_T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] coin = 2'b00;
  logic       cancel = 1'b0;
  logic       refill = 1'b0;
  logic       product, nickel_out, coin_reject, sold_out, busy;
  logic [5:0] credit;
  logic [3:0] stock;

  vend_sequencer #(.PRICE(PRICE_T), .STOCK_INIT(STOCK_T), .TIMEOUT_CYC(TIMEOUT_T)) dut (
    .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .refill(refill),
    .product(product), .nickel_out(nickel_out), .coin_reject(coin_reject),
    .credit(credit), .stock(stock), .sold_out(sold_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int edge_no;
    bit product, nickel, reject, sold, busy;
    int credit, stock;
  } snap_t;

  snap_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;

  // Reference model: sale/refund outcomes are planned as edge windows, not states.
  int k = 0;
  int m_credit, m_stock, m_idle;
  bit m_collect;
  int prod_edge, nick_start, nick_cnt, free_edge;

  function automatic int coin_value(input logic [1:0] c);
    if (c == 2'b01) return 5;
    if (c == 2'b10) return 10;
    return 0;
  endfunction

  task automatic model_step(input bit r, input logic [1:0] c, input bit cn, input bit rf);
    snap_t s;
    int    val, sum;
    bit    timed_out;
    s.edge_no = k;
    s.product = 0; s.nickel = 0; s.reject = 0; s.busy = 0;
    if (r) begin
      m_credit = 0; m_stock = STOCK_T; m_idle = 0; m_collect = 0;
      prod_edge = -1; nick_start = 0; nick_cnt = 0; free_edge = 0;
    end else begin
      val = coin_value(c);
      s.product = (k == prod_edge);
      s.nickel  = (nick_cnt > 0) && (k >= nick_start) && (k < nick_start + nick_cnt);
      s.busy    = s.product || s.nickel;
      if (s.product) m_stock = m_stock - 1;
      if (s.nickel)  m_credit = m_credit - 5;
      if (k < free_edge) begin
        s.reject = (c != 2'b00);
      end else if (!m_collect) begin
        if (val > 0 && m_stock > 0) begin
          m_credit = val; m_collect = 1; m_idle = 0;
        end else begin
          s.reject = (c != 2'b00);
        end
        if (rf) m_stock = STOCK_T;
      end else begin
        timed_out = 0;
`ifdef VEND_TIMEOUT_EN
        timed_out = (m_idle == TIMEOUT_T);
`endif
        if (cn || timed_out) begin
          s.reject   = (c != 2'b00);
          nick_start = k + 1;
          nick_cnt   = m_credit / 5;
          free_edge  = k + 1 + nick_cnt;
          m_collect  = 0;
        end else if (val > 0) begin
          m_idle = 0;
          sum = m_credit + val;
          if (sum >= PRICE_T) begin
            m_credit   = sum - PRICE_T;
            prod_edge  = k + 1;
            nick_start = k + 2;
            nick_cnt   = m_credit / 5;
            free_edge  = k + 2 + nick_cnt;
            m_collect  = 0;
          end else begin
            m_credit = sum;
          end
        end else begin
          s.reject = (c != 2'b00);
          m_idle   = m_idle + 1;
        end
      end
    end
    s.credit = m_credit;
    s.stock  = m_stock;
    s.sold   = (m_stock == 0);
    exp_q.push_back(s);
    n_pushed++;
    k++;
  endtask

  task automatic cyc(input bit r, input logic [1:0] c, input bit cn, input bit rf);
    @(negedge clk);
    rst = r; coin = c; cancel = cn; refill = rf;
    model_step(r, c, cn, rf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 0);
  endtask

  function automatic void chk(input string name, input int edge_no, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_no, act, exp);
    end
  endfunction

  // Monitor: one expected snapshot per clock, compared just after the edge.
  initial begin
    snap_t e;
    forever begin
      @(posedge clk);
      #1;
      if (n_pushed > 0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_underflow: got empty queue, expected a snapshot");
        end else begin
          e = exp_q.pop_front();
          chk("product",     e.edge_no, int'(product),     int'(e.product));
          chk("nickel_out",  e.edge_no, int'(nickel_out),  int'(e.nickel));
          chk("coin_reject", e.edge_no, int'(coin_reject), int'(e.reject));
          chk("credit",      e.edge_no, int'(credit),      e.credit);
          chk("stock",       e.edge_no, int'(stock),       e.stock);
          chk("sold_out",    e.edge_no, int'(sold_out),    int'(e.sold));
          chk("busy",        e.edge_no, int'(busy),        int'(e.busy));
        end
      end
    end
  end

  initial begin
    int r, guard;
    logic [1:0] c;
    // Reset, then three nickels: exact price, no change.
    cyc(1, 2'b00, 0, 0); cyc(1, 2'b00, 0, 0);
    cyc(0, 2'b01, 0, 0); cyc(0, 2'b01, 0, 0); cyc(0, 2'b01, 0, 0); idle(4);
    // Two dimes: one nickel of change.
    cyc(0, 2'b10, 0, 0); cyc(0, 2'b10, 0, 0); idle(5);
    // Nickel then cancel: refund.
    cyc(0, 2'b01, 0, 0); cyc(0, 2'b00, 1, 0); idle(4);
    // Cancel beats a simultaneous dime.
    cyc(0, 2'b01, 0, 0); cyc(0, 2'b10, 1, 0); idle(4);
    // Inactivity, then a cancel that only matters when no timeout is built in.
    cyc(0, 2'b10, 0, 0); idle(TIMEOUT_T + 4); cyc(0, 2'b00, 1, 0); idle(5);
    // Invalid coin in COLLECT and refill ignored while collecting.
    cyc(0, 2'b01, 0, 0); cyc(0, 2'b11, 0, 1); cyc(0, 2'b10, 0, 0); idle(4);
    // Drain stock with back-to-back sales.
    guard = 0;
    while (m_stock > 0 && guard < 20) begin
      cyc(0, 2'b10, 0, 0); cyc(0, 2'b01, 0, 0); cyc(0, 2'b11, 0, 0); cyc(0, 2'b00, 0, 0);
      guard++;
    end
    idle(2);
    cyc(0, 2'b01, 0, 0); cyc(0, 2'b11, 0, 0); cyc(0, 2'b10, 1, 0); idle(2);
    cyc(0, 2'b00, 0, 1); idle(2);
    // Reset during a two-nickel refund, after the first nickel.
    cyc(0, 2'b10, 0, 0); cyc(0, 2'b00, 1, 0); cyc(0, 2'b00, 0, 0); cyc(1, 2'b00, 0, 0); idle(5);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      c = 2'b00;
      else if (r < 78) c = 2'b01;
      else if (r < 94) c = 2'b10;
      else             c = 2'b11;
      cyc(($urandom_range(0, 199) == 0), c, ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 5));
    end
    idle(12);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending snapshots, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
